// File: rtl/led_flow_ctrl.sv
// rtl/led_flow_ctrl.sv - LED flow sequencer with prescaler, start/stop/pause and four patterns
module led_flow_ctrl #(
  parameter int N_LED = 3,
  parameter int DIV_W = 24,
  localparam int PW = $clog2(N_LED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [N_LED-1:0] led,
  output logic [PW-1:0]    pos,
  output logic             dir,
  output logic             step,
  output logic             cycle_done,
  output logic             active
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0]    M_FWD   = 2'b00;
  localparam logic [1:0]    M_REV   = 2'b01;
  localparam logic [1:0]    M_PING  = 2'b10;
  localparam logic [1:0]    M_BLINK = 2'b11;
  localparam logic [PW-1:0] LAST    = PW'(N_LED - 1);
  localparam logic [PW-1:0] ONE     = PW'(1);

  state_t           state, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [N_LED-1:0] led_d;
  logic [PW-1:0]    pos_d;
  logic             dir_d, step_d, cd_d, active_d;

  function automatic logic [N_LED-1:0] onehot(input logic [PW-1:0] p);
    onehot = {{(N_LED-1){1'b0}}, 1'b1} << p;
  endfunction

  // Next-state and next-output logic; priority is stop, then start, then the prescaled step.
  always_comb begin
    state_d  = state;
    mode_d   = mode_q;
    div_d    = div_q;
    cnt_d    = cnt;
    led_d    = led;
    pos_d    = pos;
    dir_d    = dir;
    step_d   = 1'b0;
    cd_d     = 1'b0;
    active_d = active;
    if (stop) begin
      state_d  = IDLE;
      led_d    = '0;
      pos_d    = '0;
      dir_d    = 1'b0;
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start) begin
      state_d  = RUN;
      mode_d   = mode;
      div_d    = div;
      cnt_d    = '0;
      dir_d    = 1'b0;
      active_d = 1'b1;
      case (mode)
        M_REV: begin
          pos_d = LAST;
          led_d = onehot(LAST);
        end
        M_BLINK: begin
          pos_d = '0;
          led_d = '1;
        end
        default: begin
          pos_d = '0;
          led_d = onehot('0);
        end
      endcase
    end else if (state == RUN && !pause) begin
      if (cnt == div_q) begin
        step_d = 1'b1;
        cnt_d  = '0;
        // A new div only lands at a period boundary, so the running period is never cut short.
        div_d  = div;
        case (mode_q)
          M_FWD: begin
            if (pos == LAST) begin
              pos_d = '0;
              cd_d  = 1'b1;
            end else begin
              pos_d = pos + ONE;
            end
            led_d = onehot(pos_d);
          end
          M_REV: begin
            if (pos == '0) begin
              pos_d = LAST;
              cd_d  = 1'b1;
            end else begin
              pos_d = pos - ONE;
            end
            led_d = onehot(pos_d);
          end
          M_PING: begin
            if (!dir) begin
              pos_d = pos + ONE;
              if (pos_d == LAST) dir_d = 1'b1;
            end else begin
              pos_d = pos - ONE;
              if (pos_d == '0) begin
                dir_d = 1'b0;
                cd_d  = 1'b1;
              end
            end
            led_d = onehot(pos_d);
          end
          default: begin
            // Blink: a lap ends when the LEDs come back on.
            if (led == '0) begin
              led_d = '1;
              cd_d  = 1'b1;
            end else begin
              led_d = '0;
            end
          end
        endcase
      end else begin
        cnt_d = cnt + DIV_W'(1);
      end
    end
  end

  // State and registered outputs; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mode_q     <= M_FWD;
      div_q      <= '0;
      cnt        <= '0;
      led        <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
      cycle_done <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      cnt        <= cnt_d;
      led        <= led_d;
      pos        <= pos_d;
      dir        <= dir_d;
      step       <= step_d;
      cycle_done <= cd_d;
      active     <= active_d;
    end
  end

endmodule

// File: doc/led_flow_ctrl.md
# led_flow_ctrl

Sequencing controller for the board's LED flow display. Owns the step-rate prescaler and pattern state machine, and drives a one-hot (or all-on/all-off) LED vector in forward, reverse, ping-pong or blink order. Sits between the push-button/config logic and the LED pins; replaces fixed-direction free-running flow modules with one start/stop/pause-controlled sequencer.

## Interface
- N_LED, 3: number of LEDs; legal range ≥ 2.
- DIV_W, 24: prescaler width.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse: (re)start sequencing.
- stop  in  1  single-cycle pulse: return to idle.
- pause  in  1  level: freeze sequencing while high.
- mode  in  2  pattern: 00 forward, 01 reverse, 10 ping-pong, 11 blink; sampled on start only.
- div  in  DIV_W  step period minus 1, in clk cycles.
- led  out  N_LED  LED drive, registered.
- pos  out  clog2(N_LED)  current LED index.
- dir  out  1  ping-pong direction: 0 up, 1 down.
- step  out  1  one-cycle pulse on each advance.
- cycle_done  out  1  one-cycle pulse on lap completion.
- active  out  1  high in RUN.

## Operation
- States: IDLE, RUN. Internal: mode_q, div_q, cnt[DIV_W-1:0].
- Reset: IDLE; led=0, pos=0, dir=0, step=0, cycle_done=0, active=0, cnt=0.
- Priority per cycle: stop > start > step.
- stop (any state): → IDLE; led=0, pos=0, dir=0, cnt=0, active=0.
- start (IDLE or RUN): → RUN; mode_q=mode, div_q=div, cnt=0, dir=0, active=1. Initial pos/led: forward 0/one-hot(0); reverse N_LED-1/one-hot(N_LED-1); ping-pong 0/one-hot(0); blink pos=0, led all-ones.
- RUN, pause=0: cnt==div_q → step=1, cnt=0, div_q reloaded from div, pattern advances; else cnt+1. pause=1: cnt, led, pos, dir hold; no step.
- Advance rules:
  - forward: pos==N_LED-1 → 0 with cycle_done=1; else pos+1.
  - reverse: pos==0 → N_LED-1 with cycle_done=1; else pos-1.
  - ping-pong: dir=0 → pos+1, and dir=1 on reaching N_LED-1; dir=1 → pos-1, and dir=0 plus cycle_done=1 on reaching 0. Period 2·N_LED-2 steps.
  - blink: led toggles all-ones/all-zeros; cycle_done=1 when it returns to all-ones; pos stays 0.
- In non-blink modes, led = one-hot(pos) at all times in RUN.
- mode/div changes mid-run: mode ignored until next start; new div takes effect from the next period.
- div=0: step every cycle while unpaused.

## Timing
- All outputs registered; no combinational input→output path.
- start at edge k → active, led, pos valid after edge k.
- First step is at edge k+div+1; steps then every div+1 cycles while unpaused. led/pos update on the same edge that step asserts.
- step and cycle_done are high for exactly one cycle; cycle_done is only high coincident with step.
- Paused cycles extend the period one-for-one; the count resumes from its held value.
- Reset assertion mid-RUN forces reset values immediately (asynchronous); release needs a start to resume.

## Test plan
- Reset, N_LED=3, div=2, mode=00, start → led 001,010,100,001 at 3-cycle spacing; cycle_done on the 100→001 step only.
- mode=01, start → led 100,010,001,100; cycle_done on 001→100.
- mode=10, div=0 → led 001,010,100,010,001,010 on consecutive cycles; dir rises after 100 and falls after 001; cycle_done on each return to 001.
- mode=11, div=1 → led 111,000,111 every 2 cycles; pos=0 throughout; cycle_done on each 000→111.
- Forward, div=3, pause high for 5 cycles mid-period → no step while paused; next step is delayed exactly 5 cycles; led unchanged.
- start and stop in the same cycle during RUN → IDLE, led=000, active=0. rst low mid-RUN → all outputs 0 asynchronously. start during RUN → restart at initial pattern with cnt=0.
